// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester RAM port arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address / data widths
//   STARVE_W                : width of the D starvation counter (WAIT_MAX is 1..15)
//   owner_t                 : which requester an access belongs to
//   lock_state_t            : owner FSM state (port free, or held by the CPU lock)
//   tag_t                   : per-access tag carried alongside the RAM read pipeline
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int STARVE_W   = 4;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef enum logic {
    FREE     = 1'b0,
    C_LOCKED = 1'b1
  } lock_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   is_read;
  } tag_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection for the RAM port arbiter.
//   c_req, d_req : pending requests from CPU (C) and DMA (D)
//   lock_state   : owner FSM state; while C_LOCKED only C may be granted
//   starve       : count of consecutive lost arbitrations by D
//   c_gnt, d_gnt : one-hot-or-zero grants for the current cycle
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int WAIT_MAX = 4
) (
  input  logic                c_req,
  input  logic                d_req,
  input  lock_state_t         lock_state,
  input  logic [STARVE_W-1:0] starve,
  output logic                c_gnt,
  output logic                d_gnt
);

  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (lock_state == C_LOCKED) begin
      // The CPU lock wins even over a starved D.
      c_gnt = c_req;
    end else if ((starve >= STARVE_W'(WAIT_MAX)) && d_req) begin
      d_gnt = 1'b1;
    end else begin
      c_gnt = c_req;
      d_gnt = d_req & ~c_req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read RAM port between the CPU (C) and a DMA master (D).
// One access is accepted per cycle; read data returns two cycles after acceptance
// through a tag pipe that routes it back to the requester that issued it.
//
// Handshake: a requester raises req with we/addr/wdata (and c_lock for C) and holds
// them stable until it sees gnt; the access is accepted on the rising edge where
// req & gnt are both high. gnt is combinational and may rise in the same cycle as req.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   c_req/c_we/c_addr/c_wdata/c_lock, c_gnt, c_rvalid, c_rdata   CPU side
//   d_req/d_we/d_addr/d_wdata,        d_gnt, d_rvalid, d_rdata   DMA side
//   ram_addr/ram_we/ram_wdata  registered RAM command, ram_q RAM read data
//   busy                      an access is being accepted or is still in flight
//   dbg_lock_state, dbg_starve  owner FSM state and starvation count for observation
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WAIT_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c_req,
  input  logic                c_we,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  input  logic                c_lock,
  output logic                c_gnt,
  output logic                c_rvalid,
  output logic [DATA_W-1:0]   c_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_q,
  output logic                busy,
  output lock_state_t         dbg_lock_state,
  output logic [STARVE_W-1:0] dbg_starve
);

  lock_state_t         lock_q,      lock_d;
  logic [STARVE_W-1:0] starve_q,    starve_d;
  logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
  logic                ram_we_q,    ram_we_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  tag_t                tag1_q,      tag1_d;
  tag_t                tag2_q,      tag2_d;
  logic                c_rvalid_q,  c_rvalid_d;
  logic                d_rvalid_q,  d_rvalid_d;
  logic [DATA_W-1:0]   c_rdata_q,   c_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;

  logic c_acc;
  logic d_acc;

  mem_arb_pick #(
    .WAIT_MAX (WAIT_MAX)
  ) u_pick (
    .c_req      (c_req),
    .d_req      (d_req),
    .lock_state (lock_q),
    .starve     (starve_q),
    .c_gnt      (c_gnt),
    .d_gnt      (d_gnt)
  );

  assign c_acc = c_req & c_gnt;
  assign d_acc = d_req & d_gnt;

  always_comb begin
    // Owner FSM: each accepted C access decides whether C keeps the port.
    lock_d = lock_q;
    if (c_acc) begin
      lock_d = c_lock ? C_LOCKED : FREE;
    end

    // D starvation: count lost cycles while D is waiting, saturating at WAIT_MAX.
    starve_d = starve_q;
    if (d_acc || !d_req) begin
      starve_d = '0;
    end else if (starve_q < STARVE_W'(WAIT_MAX)) begin
      starve_d = starve_q + STARVE_W'(1);
    end

    // Issue stage: address and data hold when idle, write enable is a single pulse.
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    if (c_acc) begin
      ram_addr_d  = c_addr;
      ram_wdata_d = c_wdata;
      ram_we_d    = c_we;
    end else if (d_acc) begin
      ram_addr_d  = d_addr;
      ram_wdata_d = d_wdata;
      ram_we_d    = d_we;
    end

    // tag1 lines up with ram_addr, tag2 with ram_q; the return registers then
    // capture ram_q for the owner recorded in tag2.
    tag1_d.valid   = c_acc | d_acc;
    tag1_d.owner   = c_acc ? OWN_C : OWN_D;
    tag1_d.is_read = c_acc ? ~c_we : (d_acc & ~d_we);
    tag2_d         = tag1_q;

    c_rvalid_d = tag2_q.valid & tag2_q.is_read & (tag2_q.owner == OWN_C);
    d_rvalid_d = tag2_q.valid & tag2_q.is_read & (tag2_q.owner == OWN_D);
    c_rdata_d  = c_rvalid_d ? ram_q : c_rdata_q;
    d_rdata_d  = d_rvalid_d ? ram_q : d_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q      <= FREE;
      starve_q    <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      c_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      lock_q      <= lock_d;
      starve_q    <= starve_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      c_rvalid_q  <= c_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign ram_addr       = ram_addr_q;
  assign ram_we         = ram_we_q;
  assign ram_wdata      = ram_wdata_q;
  assign c_rvalid       = c_rvalid_q;
  assign d_rvalid       = d_rvalid_q;
  assign c_rdata        = c_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign busy           = c_acc | d_acc | tag1_q.valid | tag2_q.valid;
  assign dbg_lock_state = lock_q;
  assign dbg_starve     = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a RAM model drives ram_q, directed scenarios pin
// hand-computed values, and a per-cycle compare process checks every output
// against a transaction-level model (grant rules, memory array, return schedule).
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int WM = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          c_req, c_we, c_lock, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_q;
  logic          busy;
  lock_state_t   dbg_lock_state;
  logic [3:0]    dbg_starve;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_lock(c_lock),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q),
    .busy(busy), .dbg_lock_state(dbg_lock_state), .dbg_starve(dbg_starve)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 5) return 16'h1234;
    return 16'(16'hA000 + i);
  endfunction

  // Write-first synchronous RAM.
  logic          ram_init;
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= init_val(i);
      ram_q <= '0;
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_q <= ram_we ? ram_wdata : ram_mem[ram_addr];
    end
  end

  // ---------------- scoreboard / reporting ----------------
  int checks = 0;
  int failures = 0;
  logic [DW:0] exp_q[$];  // {owner_is_d, data} in acceptance order

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + compare ----------------
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  bit            m_locked;
  int            m_starve;
  bit            m_c_acc, m_d_acc;
  bit            acc1, acc2;
  bit            pend_we;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  logic [AW-1:0] exp_addr;
  logic          exp_we;
  logic [DW-1:0] exp_wdata;
  bit            exp_crv [8];
  bit            exp_drv [8];

  initial begin : compare
    int k;
    int slot;
    bit cg, dg, acc_now;
    logic [DW:0] e;
    k = 0;
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      #2;
      slot = k % 8;
      if (rst) begin
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        chk("rst_c_rvalid", 32'(c_rvalid), 0);
        chk("rst_d_rvalid", 32'(d_rvalid), 0);
        chk("rst_c_rdata", 32'(c_rdata), 0);
        chk("rst_d_rdata", 32'(d_rdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(dbg_lock_state), 32'(FREE));
        chk("rst_starve", 32'(dbg_starve), 0);
        m_locked = 0; m_starve = 0; m_c_acc = 0; m_d_acc = 0;
        acc1 = 0; acc2 = 0; pend_we = 0;
        exp_addr = '0; exp_we = 1'b0; exp_wdata = '0;
        for (int i = 0; i < 8; i++) begin exp_crv[i] = 0; exp_drv[i] = 0; end
        exp_q.delete();
      end else begin
        // A write reaches the RAM on the edge after it was issued.
        if (pend_we) m_mem[pend_addr] = pend_data;
        pend_we = 0;

        if (m_locked) begin
          cg = c_req; dg = 0;
        end else if (m_starve >= WM && d_req) begin
          cg = 0; dg = 1;
        end else begin
          cg = c_req; dg = d_req && !c_req;
        end
        acc_now = cg || dg;

        chk("c_gnt", 32'(c_gnt), 32'(cg));
        chk("d_gnt", 32'(d_gnt), 32'(dg));
        chk("owner", 32'(dbg_lock_state), m_locked ? 32'(C_LOCKED) : 32'(FREE));
        chk("starve", 32'(dbg_starve), 32'(m_starve));
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
        if (exp_we) chk("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
        chk("busy", 32'(busy), 32'(acc_now || acc1 || acc2));
        chk("c_rvalid", 32'(c_rvalid), 32'(exp_crv[slot]));
        chk("d_rvalid", 32'(d_rvalid), 32'(exp_drv[slot]));
        if (exp_crv[slot] || exp_drv[slot]) begin
          if (exp_q.size() == 0) begin
            chk("exp_q_underflow", 1, 0);
          end else begin
            e = exp_q.pop_front();
            if (exp_crv[slot]) chk("c_rdata", 32'(c_rdata), 32'(e[DW-1:0]));
            else               chk("d_rdata", 32'(d_rdata), 32'(e[DW-1:0]));
          end
        end
        exp_crv[slot] = 0;
        exp_drv[slot] = 0;
        acc2 = acc1;
        acc1 = acc_now;

        exp_we = 1'b0;
        if (cg) begin
          exp_addr = c_addr; exp_we = c_we;
          if (c_we) begin
            exp_wdata = c_wdata; pend_we = 1; pend_addr = c_addr; pend_data = c_wdata;
          end else begin
            exp_crv[(k + 3) % 8] = 1;
            exp_q.push_back({1'b0, m_mem[c_addr]});
          end
          m_locked = c_lock;
        end else if (dg) begin
          exp_addr = d_addr; exp_we = d_we;
          if (d_we) begin
            exp_wdata = d_wdata; pend_we = 1; pend_addr = d_addr; pend_data = d_wdata;
          end else begin
            exp_drv[(k + 3) % 8] = 1;
            exp_q.push_back({1'b1, m_mem[d_addr]});
          end
        end
        if (dg || !d_req) m_starve = 0;
        else if (m_starve < WM) m_starve = m_starve + 1;
        m_c_acc = cg;
        m_d_acc = dg;
      end
      k++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      c_req = 0; c_we = 0; c_lock = 0; d_req = 0; d_we = 0;
    end
  endtask

  task automatic c_set(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic lk);
    c_req = 1; c_we = we; c_addr = a; c_wdata = wd; c_lock = lk;
  endtask

  task automatic d_set(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [5:0] t2_seq;
    int we_pulses;
    bit c_pend, d_pend;
    rst = 1; ram_init = 1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_lock = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    ram_init = 0;
    @(negedge clk);
    rst = 0;

    // 1: single CPU read of RAM[5]
    idle(3);
    @(negedge clk); c_set(0, 10'h005, '0, 0); #3;
    chk("t1_c_gnt", 32'(c_gnt), 1);
    @(negedge clk); c_req = 0; #3;
    chk("t1_ram_addr", 32'(ram_addr), 32'h005);
    chk("t1_ram_we", 32'(ram_we), 0);
    @(negedge clk);
    @(negedge clk); #3;
    chk("t1_c_rvalid", 32'(c_rvalid), 1);
    chk("t1_c_rdata", 32'(c_rdata), 32'h1234);

    // 2: both requesting for 6 cycles -> C,C,C,C,D,C
    idle(4);
    t2_seq = 6'b101111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); c_set(0, 10'h020, '0, 0); d_set(0, 10'h021, '0); #3;
      chk("t2_c_gnt", 32'(c_gnt), 32'(t2_seq[i]));
      chk("t2_d_gnt", 32'(d_gnt), 32'(!t2_seq[i]));
      if (i == 5) chk("t2_starve_cleared", 32'(dbg_starve), 0);
    end

    // 3: locked write then unlocked read, D waiting throughout
    idle(5);
    @(negedge clk); c_set(1, 10'h010, 16'hBEEF, 1); d_set(0, 10'h030, '0); #3;
    chk("t3_c_gnt_w", 32'(c_gnt), 1);
    chk("t3_d_gnt_w", 32'(d_gnt), 0);
    repeat (3) begin
      @(negedge clk); c_req = 0; c_lock = 0; #3;
      chk("t3_d_gnt_locked", 32'(d_gnt), 0);
      chk("t3_owner_locked", 32'(dbg_lock_state), 32'(C_LOCKED));
    end
    @(negedge clk); c_set(0, 10'h010, '0, 0); #3;
    chk("t3_c_gnt_r", 32'(c_gnt), 1);
    chk("t3_d_gnt_r", 32'(d_gnt), 0);
    @(negedge clk); c_req = 0; #3;
    chk("t3_d_gnt_after", 32'(d_gnt), 1);
    @(negedge clk); d_req = 0;
    @(negedge clk); #3;
    chk("t3_c_rvalid", 32'(c_rvalid), 1);
    chk("t3_c_rdata", 32'(c_rdata), 32'hBEEF);

    // 4: C read, D read, C write back to back
    idle(5);
    we_pulses = 0;
    @(negedge clk); c_set(0, 10'h001, '0, 0); #3;
    chk("t4_c_gnt0", 32'(c_gnt), 1);
    we_pulses += int'(ram_we);
    @(negedge clk); c_req = 0; d_set(0, 10'h002, '0); #3;
    chk("t4_d_gnt1", 32'(d_gnt), 1);
    we_pulses += int'(ram_we);
    @(negedge clk); d_req = 0; c_set(1, 10'h003, 16'h5A5A, 0); #3;
    chk("t4_c_gnt2", 32'(c_gnt), 1);
    we_pulses += int'(ram_we);
    @(negedge clk); c_req = 0; c_we = 0; #3;
    chk("t4_c_rvalid", 32'(c_rvalid), 1);
    chk("t4_c_rdata", 32'(c_rdata), 32'hA001);
    chk("t4_d_rvalid_early", 32'(d_rvalid), 0);
    we_pulses += int'(ram_we);
    @(negedge clk); #3;
    chk("t4_d_rvalid", 32'(d_rvalid), 1);
    chk("t4_d_rdata", 32'(d_rdata), 32'hA002);
    chk("t4_c_rvalid_off", 32'(c_rvalid), 0);
    we_pulses += int'(ram_we);
    repeat (2) begin
      @(negedge clk); #3;
      chk("t4_no_wr_rvalid", 32'(c_rvalid | d_rvalid), 0);
      we_pulses += int'(ram_we);
    end
    chk("t4_we_pulses", 32'(we_pulses), 1);

    // 5: reset while a D read is in flight and C holds the lock
    idle(4);
    @(negedge clk); d_set(0, 10'h007, '0); #3;
    chk("t5_d_gnt", 32'(d_gnt), 1);
    @(negedge clk); d_req = 0; c_set(1, 10'h011, 16'h7777, 1); #3;
    chk("t5_c_gnt", 32'(c_gnt), 1);
    @(negedge clk); c_req = 0; c_we = 0; c_lock = 0;
    chk("t5_owner_before", 32'(dbg_lock_state), 32'(C_LOCKED));
    chk("t5_ram_we_before", 32'(ram_we), 1);
    rst = 1; #3;
    chk("t5_ram_we_async", 32'(ram_we), 0);
    chk("t5_owner_free", 32'(dbg_lock_state), 32'(FREE));
    chk("t5_busy", 32'(busy), 0);
    @(negedge clk); #3;
    chk("t5_d_rvalid_rst", 32'(d_rvalid), 0);
    @(negedge clk); rst = 0;
    repeat (4) begin
      @(negedge clk); #3;
      chk("t5_d_rvalid_dropped", 32'(d_rvalid), 0);
    end

    // 6: idle
    repeat (3) begin
      @(negedge clk); c_req = 0; d_req = 0; #3;
      chk("t6_busy", 32'(busy), 0);
      chk("t6_ram_we", 32'(ram_we), 0);
      chk("t6_gnts", 32'({c_gnt, d_gnt}), 0);
    end

    // Random traffic under the req-hold protocol.
    c_pend = 0; d_pend = 0;
    repeat (600) begin
      @(negedge clk);
      if (m_c_acc) c_pend = 0;
      if (m_d_acc) d_pend = 0;
      if (!c_pend && $urandom_range(0, 99) < 50) begin
        c_pend = 1;
        c_set(1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)),
              16'($urandom), 1'($urandom_range(0, 3) == 0));
      end
      if (!d_pend && $urandom_range(0, 99) < 60) begin
        d_pend = 1;
        d_set(1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), 16'($urandom));
      end
      c_req = c_pend;
      d_req = d_pend;
    end
    idle(8);
    chk("drain_exp_q", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
